// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
//
// MEM-stage data-memory access unit. Accepts a load/store from the decoded
// control word, drives the data-memory port with a word address, byte mask and
// lane-replicated write data, stalls the pipeline while the access is
// outstanding, and returns sign/zero-extended load data with a one-cycle done
// pulse. Illegal funct3, misaligned addresses and memory timeouts are flagged.
//
// Parameters:
//   TIMEOUT           BUSY cycles without dmem_resp before abandoning (0 = off)
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid         MEM-stage instruction valid
//   mem_read          load request
//   mem_write         store request
//   funct3            load/store width and signedness encoding
//   addr              effective byte address
//   store_data        rs2 value to store
//   dmem_read         registered memory read strobe
//   dmem_write        registered memory write strobe
//   dmem_address      word-aligned memory address
//   dmem_wdata        lane-replicated store data
//   dmem_byte_enable  store byte mask (0 for loads)
//   dmem_rdata        memory read data
//   dmem_resp         memory completion
//   stall             hold upstream pipeline registers
//   load_data         extended load result, valid while done=1
//   done              one-cycle completion pulse
//   fault             fault indication
//   fault_cause       0 none, 1 misaligned, 2 illegal, 3 timeout
// -----------------------------------------------------------------------------
module dmem_access_unit #(
    parameter int unsigned TIMEOUT = 32'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam int unsigned CW = (TIMEOUT < 32'd2) ? 32'd1 : $clog2(TIMEOUT + 32'd1);
    // Count value seen in the last permitted BUSY cycle.
    localparam logic [CW-1:0] LIMIT_M1 = (TIMEOUT == 32'd0) ? {CW{1'b0}} : CW'(TIMEOUT - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Legal funct3 for the requested operation; read+write together is illegal.
    function automatic logic f_legal(input logic rd, input logic wr, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (rd && wr) begin
            ok = 1'b0;
        end else if (rd) begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
                default:                                ok = 1'b0;
            endcase
        end else if (wr) begin
            case (f3)
                3'b000, 3'b001, 3'b010: ok = 1'b1;
                default:                ok = 1'b0;
            endcase
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Natural alignment by access size (funct3[1:0]: byte, half, word).
    function automatic logic f_aligned(input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~a[0];
            2'b10:   ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Store byte mask positioned on the addressed lane.
    function automatic logic [3:0] f_byte_en(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << a;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the store value across all lanes so the mask alone selects it.
    function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Shift the addressed lane down and extend it per funct3.
    function automatic logic [31:0] f_extract(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rdata);
        logic [31:0] lane;
        logic [31:0] res;
        lane = rdata >> {a, 3'b000};
        case (f3)
            3'b000:  res = {{24{lane[7]}}, lane[7:0]};
            3'b001:  res = {{16{lane[15]}}, lane[15:0]};
            3'b010:  res = rdata;
            3'b100:  res = {24'd0, lane[7:0]};
            3'b101:  res = {16'd0, lane[15:0]};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic            r_is_load;
    logic            r_dmem_read;
    logic            r_dmem_write;
    logic [31:0]     r_dmem_address;
    logic [31:0]     r_dmem_wdata;
    logic [3:0]      r_dmem_be;
    logic [31:0]     r_load_data;
    logic            r_timeout;
    logic [CW-1:0]   r_cnt;

    logic            w_has_op;
    logic            w_legal;
    logic            w_aligned;
    logic            w_accept;
    logic            w_idle_fault;
    logic            w_expire;

    // Request qualification in IDLE; gated by rst_n so outputs stay 0 in reset.
    always_comb begin
        w_has_op     = req_valid & (mem_read | mem_write);
        w_legal      = f_legal(mem_read, mem_write, funct3);
        w_aligned    = f_aligned(funct3, addr[1:0]);
        w_accept     = rst_n & (r_state == ST_IDLE) & w_has_op & w_legal & w_aligned;
        w_idle_fault = rst_n & (r_state == ST_IDLE) & w_has_op & ~(w_legal & w_aligned);
        w_expire     = (TIMEOUT != 32'd0) && (r_cnt == LIMIT_M1) && !dmem_resp;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a response in the expiry cycle completes normally.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_BUSY;
                else          w_next = ST_IDLE;
            end
            ST_BUSY: begin
                if (dmem_resp)     w_next = ST_DONE;
                else if (w_expire) w_next = ST_DONE;
                else               w_next = ST_BUSY;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Memory port, timeout counter and load-result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f3           <= 3'd0;
            r_off          <= 2'd0;
            r_is_load      <= 1'b0;
            r_dmem_read    <= 1'b0;
            r_dmem_write   <= 1'b0;
            r_dmem_address <= 32'd0;
            r_dmem_wdata   <= 32'd0;
            r_dmem_be      <= 4'd0;
            r_load_data    <= 32'd0;
            r_timeout      <= 1'b0;
            r_cnt          <= {CW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_f3           <= funct3;
                        r_off          <= addr[1:0];
                        r_is_load      <= mem_read;
                        r_dmem_read    <= mem_read;
                        r_dmem_write   <= mem_write;
                        r_dmem_address <= {addr[31:2], 2'b00};
                        r_dmem_wdata   <= mem_write ? f_wdata(funct3, store_data) : 32'd0;
                        r_dmem_be      <= mem_write ? f_byte_en(funct3, addr[1:0]) : 4'd0;
                        r_cnt          <= {CW{1'b0}};
                    end else begin
                        r_cnt          <= {CW{1'b0}};
                    end
                    r_load_data <= 32'd0;
                    r_timeout   <= 1'b0;
                end
                ST_BUSY: begin
                    if (dmem_resp || w_expire) begin
                        r_dmem_read    <= 1'b0;
                        r_dmem_write   <= 1'b0;
                        r_dmem_address <= 32'd0;
                        r_dmem_wdata   <= 32'd0;
                        r_dmem_be      <= 4'd0;
                        r_cnt          <= {CW{1'b0}};
                        r_timeout      <= ~dmem_resp;
                        r_load_data    <= (dmem_resp && r_is_load) ?
                                          f_extract(r_f3, r_off, dmem_rdata) : 32'd0;
                    end else begin
                        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    r_load_data <= 32'd0;
                    r_timeout   <= 1'b0;
                    r_is_load   <= 1'b0;
                end
                default: begin
                    r_dmem_read  <= 1'b0;
                    r_dmem_write <= 1'b0;
                    r_load_data  <= 32'd0;
                    r_timeout    <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline handshake and fault reporting; IDLE faults are combinational.
    always_comb begin
        stall       = w_accept | (r_state == ST_BUSY);
        done        = (r_state == ST_DONE);
        fault       = 1'b0;
        fault_cause = 2'd0;
        if (w_idle_fault) begin
            fault       = 1'b1;
            fault_cause = w_legal ? 2'd1 : 2'd2;
        end else if ((r_state == ST_DONE) && r_timeout) begin
            fault       = 1'b1;
            fault_cause = 2'd3;
        end else begin
            fault       = 1'b0;
            fault_cause = 2'd0;
        end
    end

    assign dmem_read        = r_dmem_read;
    assign dmem_write       = r_dmem_write;
    assign dmem_address     = r_dmem_address;
    assign dmem_wdata       = r_dmem_wdata;
    assign dmem_byte_enable = r_dmem_be;
    assign load_data        = r_load_data;

endmodule

// File: tb/tb_dmem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_unit
//
// Self-checking bench: directed scenarios plus randomized loads/stores, each
// checked cycle by cycle against a behavioural model of the access rules.
// -----------------------------------------------------------------------------
module tb_dmem_access_unit;

    localparam int TMO = 8;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        stall;
    logic [31:0] load_data;
    logic        done;
    logic        fault;
    logic [1:0]  fault_cause;

    int n_checks;
    int n_fail;

    dmem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .funct3           (funct3),
        .addr             (addr),
        .store_data       (store_data),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .stall            (stall),
        .load_data        (load_data),
        .done             (done),
        .fault            (fault),
        .fault_cause      (fault_cause)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (access rules as plain arithmetic) -----
    function automatic bit m_legal(bit rd, bit wr, int f3);
        if (rd && wr) return 1'b0;
        if (rd) return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        if (wr) return (f3 <= 2);
        return 1'b0;
    endfunction

    function automatic int m_size(int f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic logic [31:0] m_load(int f3, logic [31:0] a, logic [31:0] rdata);
        logic [31:0] lane;
        logic [7:0]  b;
        logic [15:0] h;
        lane = rdata >> (8 * (a % 4));
        b = lane[7:0];
        h = lane[15:0];
        case (f3)
            0:       return 32'($signed(b));
            1:       return 32'($signed(h));
            2:       return rdata;
            4:       return 32'(b);
            5:       return 32'(h);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_rd"},    32'(dmem_read),  32'd0);
        check_eq({tag, "_wr"},    32'(dmem_write), 32'd0);
        check_eq({tag, "_stall"}, 32'(stall),      32'd0);
        check_eq({tag, "_done"},  32'(done),       32'd0);
    endtask

    // One request: delay = BUSY cycles before resp (resp on cycle delay+1), -1 = never.
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input int delay, input logic [31:0] rdata);
        bit          legal;
        bit          aligned;
        logic [31:0] exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_ld;
        int          k;
        bit          fin;
        bit          to;
        legal   = m_legal(rd, wr, int'(f3));
        aligned = (a % m_size(int'(f3))) == 0;
        exp_be  = wr ? ((((32'd1 << m_size(int'(f3))) - 32'd1) << (a % 4)) & 32'hF) : 32'd0;
        case (m_size(int'(f3)))
            1:       exp_wd = {24'd0, sd[7:0]} * 32'h01010101;
            2:       exp_wd = {16'd0, sd[15:0]} * 32'h00010001;
            default: exp_wd = sd;
        endcase

        @(negedge clk);
        req_valid = 1'b1; mem_read = rd; mem_write = wr;
        funct3 = f3; addr = a; store_data = sd; dmem_resp = 1'b0;
        #1;
        if (!(rd || wr)) begin
            check_quiet("noop");
            check_eq("noop_fault", 32'(fault), 32'd0);
            req_valid = 1'b0;
            return;
        end
        if (!(legal && aligned)) begin
            check_eq("bad_fault", 32'(fault), 32'd1);
            check_eq("bad_cause", 32'(fault_cause), legal ? 32'd1 : 32'd2);
            check_eq("bad_stall", 32'(stall), 32'd0);
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check_quiet("bad_after");
            return;
        end
        check_eq("acc_stall", 32'(stall), 32'd1);
        check_eq("acc_fault", 32'(fault), 32'd0);

        k = 0; fin = 1'b0; to = 1'b0;
        while (!fin) begin
            @(negedge clk);
            k++;
            req_valid = 1'($urandom_range(0, 1));
            if (delay >= 0 && k == delay + 1) begin
                dmem_resp = 1'b1; dmem_rdata = rdata;
            end else begin
                dmem_resp = 1'b0; dmem_rdata = $urandom;
            end
            #1;
            check_eq("busy_rd",    32'(dmem_read),  32'(rd));
            check_eq("busy_wr",    32'(dmem_write), 32'(wr));
            check_eq("busy_addr",  dmem_address,    a & 32'hFFFFFFFC);
            check_eq("busy_be",    32'(dmem_byte_enable), exp_be);
            if (wr) check_eq("busy_wdata", dmem_wdata, exp_wd);
            check_eq("busy_stall", 32'(stall), 32'd1);
            check_eq("busy_done",  32'(done),  32'd0);
            if (dmem_resp) begin
                fin = 1'b1;
            end else if (k == TMO) begin
                fin = 1'b1; to = 1'b1;
            end else if (k > 4 * TMO) begin
                check_eq("busy_bound", 32'(k), 32'(TMO));
                fin = 1'b1;
            end
        end
        exp_ld = (rd && !to) ? m_load(int'(f3), a, rdata) : 32'd0;

        // DONE: request held valid to confirm it is not reissued.
        @(negedge clk);
        dmem_resp = 1'b0; req_valid = 1'b1;
        #1;
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("done_stall", 32'(stall), 32'd0);
        check_eq("done_ld",    load_data, exp_ld);
        check_eq("done_fault", 32'(fault), 32'(to));
        check_eq("done_cause", 32'(fault_cause), to ? 32'd3 : 32'd0);
        check_eq("done_rd",    32'(dmem_read),  32'd0);
        check_eq("done_wr",    32'(dmem_write), 32'd0);

        @(negedge clk);
        req_valid = 1'b0;
        dmem_resp = to;  // late response after a timeout must be ignored
        #1;
        check_quiet("post");
        check_eq("post_ld",    load_data, 32'd0);
        check_eq("post_fault", 32'(fault), 32'd0);
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        check_eq("post2_done", 32'(done), 32'd0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
        dmem_rdata = 32'd0; dmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset");
        check_eq("reset_ld",    load_data,          32'd0);
        check_eq("reset_fault", 32'(fault),         32'd0);
        check_eq("reset_addr",  dmem_address,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios.
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'd0, 3, 32'hDEADBEEF);
        run_txn(1'b0, 1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 2, 32'd0);
        run_txn(1'b1, 1'b0, 3'b000, 32'h0000_3002, 32'd0, 1, 32'h80FF7F01);
        run_txn(1'b1, 1'b0, 3'b100, 32'h0000_3002, 32'd0, 0, 32'h80FF7F01);
        run_txn(1'b1, 1'b0, 3'b001, 32'h0000_3002, 32'd0, 2, 32'h80FF7F01);
        run_txn(1'b1, 1'b0, 3'b101, 32'h0000_3002, 32'd0, 1, 32'h80FF7F01);
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'd0, 0, 32'd0);
        run_txn(1'b0, 1'b1, 3'b001, 32'h0000_1001, 32'd0, 0, 32'd0);
        run_txn(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'd0, 0, 32'd0);
        run_txn(1'b1, 1'b1, 3'b010, 32'h0000_1000, 32'd0, 0, 32'd0);
        run_txn(1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'h1234_5678, -1, 32'd0);
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_4004, 32'd0, TMO - 1, 32'hCAFEF00D);

        // Reset in the middle of a read, with the request still presented.
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        funct3 = 3'b010; addr = 32'h0000_5000;
        repeat (3) @(negedge clk);
        #1;
        check_eq("pre_rst_rd", 32'(dmem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        check_quiet("rst_busy");
        check_eq("rst_addr",  dmem_address, 32'd0);
        check_eq("rst_fault", 32'(fault),   32'd0);
        @(negedge clk);
        rst_n = 1'b1; req_valid = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'h1111_2222;
        #1;
        check_quiet("late_resp");
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        check_quiet("late_resp2");
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'd0, 2, 32'h5A5A_0FF0);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            int          op;
            bit          rd;
            bit          wr;
            logic [2:0]  f3;
            int          dly;
            logic [2:0]  legal_f3 [5];
            legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            op = int'($urandom_range(0, 9));
            rd = (op == 1) || (op >= 2 && op <= 5);
            wr = (op == 1) || (op >= 6);
            if ($urandom_range(0, 9) < 7) f3 = legal_f3[$urandom_range(0, wr ? 2 : 4)];
            else                          f3 = 3'($urandom_range(0, 7));
            dly = int'($urandom_range(0, 9));
            if (dly == 9) dly = -1;
            run_txn(rd, wr, f3, $urandom, $urandom, dly, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                req_valid = 1'b0;
                #1;
                check_quiet("idle_gap");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
